// File: rtl/sim_pkg.sv
// Shared types and constants for the cloth/rope step sequencer and node array.
package sim_pkg;

   localparam int unsigned COORD_W       = 32;
   localparam int unsigned ANCHOR_X_INIT = 200;
   localparam int unsigned ANCHOR_Y_INIT = 10;

   typedef enum logic [1:0] {
      IDLE,
      VERLET,
      CONSTRAIN,
      DONE
   } sim_state_e;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter with zero flag and hold; times both step phases.
module phase_counter #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   input  logic             hold,
   output logic             zero_c
);

   logic [CNT_W-1:0] count;

   // Load takes priority; counting saturates at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && !hold && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero_c = (count == '0);

endmodule

// File: rtl/sim_step_sequencer.sv
// Per-step phase sequencer (Verlet, then constraint relaxation, then done) with pin anchor register.
// Optional SIM_PAUSE_EN adds a pause input that stalls the active phases.
module sim_step_sequencer #(
   parameter int unsigned COORD_W          = sim_pkg::COORD_W,
   parameter int unsigned ANCHOR_X_INIT    = sim_pkg::ANCHOR_X_INIT,
   parameter int unsigned ANCHOR_Y_INIT    = sim_pkg::ANCHOR_Y_INIT,
   parameter int unsigned VERLET_CYCLES    = 1,
   parameter int unsigned CONSTRAINT_ITERS = 4,
   parameter int unsigned FRAME_W          = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
`ifdef SIM_PAUSE_EN
   input  logic               pause,
`endif
   input  logic               anchor_we,
   input  logic [COORD_W-1:0] anchor_x,
   input  logic [COORD_W-1:0] anchor_y,
   output logic               verlet_state,
   output logic               fix_constraint_state,
   output logic [COORD_W-1:0] fix_x,
   output logic [COORD_W-1:0] fix_y,
   output logic               busy,
   output logic               done,
   output logic [FRAME_W-1:0] frame_cnt
);

   import sim_pkg::*;

   localparam int unsigned CNT_MAX = (VERLET_CYCLES > CONSTRAINT_ITERS) ? VERLET_CYCLES
                                                                         : CONSTRAINT_ITERS;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   sim_state_e       state;
   logic             verlet_q;
   logic             constrain_q;
   logic             stall_c;
   logic             active_c;
   logic             cnt_load_c;
   logic             cnt_zero_c;
   logic [CNT_W-1:0] cnt_load_val_c;

   assign active_c = (state == VERLET) || (state == CONSTRAIN);

`ifdef SIM_PAUSE_EN
   // Pause only stalls the active phases; the done pulse is never stretched.
   assign stall_c = pause & active_c;
`else
   assign stall_c = 1'b0;
`endif

   // Nodes must idle in exactly the cycles pause is high, so the strobes are masked in-cycle.
   assign verlet_state         = verlet_q & ~stall_c;
   assign fix_constraint_state = constrain_q & ~stall_c;

   assign cnt_load_c     = ((state == IDLE) && start) ||
                           ((state == VERLET) && cnt_zero_c && !stall_c);
   assign cnt_load_val_c = (state == IDLE) ? CNT_W'(VERLET_CYCLES - 1)
                                           : CNT_W'(CONSTRAINT_ITERS - 1);

   phase_counter #(
      .CNT_W (CNT_W)
   ) u_phase_counter (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load_c),
      .load_val (cnt_load_val_c),
      .en       (active_c),
      .hold     (stall_c),
      .zero_c   (cnt_zero_c)
   );

   // Step FSM; outputs are registered alongside the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         verlet_q    <= 1'b0;
         constrain_q <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         frame_cnt   <= '0;
         fix_x       <= COORD_W'(ANCHOR_X_INIT);
         fix_y       <= COORD_W'(ANCHOR_Y_INIT);
      end else begin
         if (anchor_we && ((state == IDLE) || (state == DONE))) begin
            fix_x <= anchor_x;
            fix_y <= anchor_y;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= VERLET;
                  verlet_q <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            VERLET: begin
               if (!stall_c && cnt_zero_c) begin
                  state       <= CONSTRAIN;
                  verlet_q    <= 1'b0;
                  constrain_q <= 1'b1;
               end
            end
            CONSTRAIN: begin
               if (!stall_c && cnt_zero_c) begin
                  state       <= DONE;
                  constrain_q <= 1'b0;
                  done        <= 1'b1;
                  frame_cnt   <= frame_cnt + FRAME_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state       <= IDLE;
               verlet_q    <= 1'b0;
               constrain_q <= 1'b0;
               done        <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sim_step_sequencer.sv
// Scoreboard bench for sim_step_sequencer: window-based step model, done-pulse queue, random stimulus.
module tb_sim_step_sequencer;

   localparam int unsigned CW   = 32;
   localparam int unsigned FW   = 8;
   localparam int          V    = 1;
   localparam int          C    = 4;
   localparam int          STEP = V + C + 1;

   logic          clk       = 1'b0;
   logic          reset     = 1'b0;
   logic          start     = 1'b0;
   logic          anchor_we = 1'b0;
   logic [CW-1:0] anchor_x  = '0;
   logic [CW-1:0] anchor_y  = '0;
   logic          verlet_state;
   logic          fix_constraint_state;
   logic          busy;
   logic          done;
   logic [CW-1:0] fix_x;
   logic [CW-1:0] fix_y;
   logic [FW-1:0] frame_cnt;

   typedef struct {
      int            done_cyc;
      logic [FW-1:0] frame;
      logic [CW-1:0] fx;
      logic [CW-1:0] fy;
   } exp_t;

   exp_t exp_q[$];

   int            cyc      = 0;
   int            n_checks = 0;
   int            n_fail   = 0;
   bit            check_en = 1'b0;
   bit            mactive  = 1'b0;
   int            mk       = 0;
   logic [FW-1:0] mframe   = '0;
   logic [CW-1:0] mfx      = CW'(200);
   logic [CW-1:0] mfy      = CW'(10);
   int            n_acc    = 0;
   int            n_abort  = 0;
   int            n_done   = 0;
   bit            wrapped  = 1'b0;

   sim_step_sequencer #(
      .VERLET_CYCLES    (V),
      .CONSTRAINT_ITERS (C),
      .FRAME_W          (FW)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .start                (start),
`ifdef SIM_PAUSE_EN
      .pause                (1'b0),
`endif
      .anchor_we            (anchor_we),
      .anchor_x             (anchor_x),
      .anchor_y             (anchor_y),
      .verlet_state         (verlet_state),
      .fix_constraint_state (fix_constraint_state),
      .fix_x                (fix_x),
      .fix_y                (fix_y),
      .busy                 (busy),
      .done                 (done),
      .frame_cnt            (frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a step accepted at edge k occupies cycles k+1 .. k+STEP.
   always @(posedge clk) begin
      bit in_phase;
      bit idle;
      if (reset) begin
         if (mactive && cyc < mk + STEP && exp_q.size() > 0) begin
            exp_q.delete(exp_q.size() - 1);
            n_abort++;
         end
         mactive = 1'b0;
         mframe  = '0;
         mfx     = CW'(200);
         mfy     = CW'(10);
      end else begin
         in_phase = mactive && (cyc >= mk + 1) && (cyc <= mk + V + C);
         idle     = !mactive || (cyc > mk + STEP);
         if (anchor_we && !in_phase) begin
            mfx = anchor_x;
            mfy = anchor_y;
         end
         if (start && idle) begin
            mactive = 1'b1;
            mk      = cyc;
            mframe  = mframe + FW'(1);
            n_acc++;
            exp_q.push_back('{done_cyc: cyc + STEP, frame: mframe, fx: mfx, fy: mfy});
         end
      end
      cyc = cyc + 1;
   end

   // Monitor: per-cycle strobe windows plus scoreboard pop on every done pulse.
   always @(negedge clk) begin
      bit            ev;
      bit            ec;
      bit            eb;
      bit            ed;
      logic [FW-1:0] ef;
      exp_t          e;
      if (check_en) begin
         ev = mactive && (cyc >= mk + 1) && (cyc <= mk + V);
         ec = mactive && (cyc >= mk + V + 1) && (cyc <= mk + V + C);
         eb = mactive && (cyc >= mk + 1) && (cyc <= mk + STEP);
         ed = mactive && (cyc == mk + STEP);
         ef = (mactive && cyc < mk + STEP) ? mframe - FW'(1) : mframe;
         check("verlet_state", 64'(verlet_state), 64'(ev));
         check("fix_constraint_state", 64'(fix_constraint_state), 64'(ec));
         check("busy", 64'(busy), 64'(eb));
         check("done", 64'(done), 64'(ed));
         check("frame_cnt", 64'(frame_cnt), 64'(ef));
         check("fix_x", 64'(fix_x), 64'(mfx));
         check("fix_y", 64'(fix_y), 64'(mfy));
         if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
               check("done_unexpected", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("done_cycle", 64'(cyc), 64'(e.done_cyc));
               check("done_frame", 64'(frame_cnt), 64'(e.frame));
               check("done_fix_x", 64'(fix_x), 64'(e.fx));
               check("done_fix_y", 64'(fix_y), 64'(e.fy));
               if (e.frame == '0) wrapped = 1'b1;
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      tick();
      tick();
      reset    = 1'b0;
      check_en = 1'b1;
      repeat (2) tick();

      // Nominal step with a re-pulsed start and a dropped anchor write in cycle 3.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      start     = 1'b1;
      anchor_we = 1'b1;
      anchor_x  = CW'(50);
      anchor_y  = CW'(60);
      tick();
      start     = 1'b0;
      anchor_we = 1'b0;
      repeat (5) tick();

      // Anchor write accepted in IDLE.
      anchor_we = 1'b1;
      tick();
      anchor_we = 1'b0;
      tick();

      // Anchor write together with start: step runs with the new anchor.
      start     = 1'b1;
      anchor_we = 1'b1;
      anchor_x  = CW'(77);
      anchor_y  = CW'(88);
      tick();
      start     = 1'b0;
      anchor_we = 1'b0;
      repeat (8) tick();

      // Reset in cycle 4 of a step (CONSTRAIN): no done pulse.
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (8) tick();

      // Randomised traffic including occasional resets.
      repeat (600) begin
         start     = ($urandom_range(0, 2) == 0);
         anchor_we = ($urandom_range(0, 3) == 0);
         anchor_x  = $urandom;
         anchor_y  = $urandom;
         reset     = ($urandom_range(0, 59) == 0);
         tick();
      end
      reset     = 1'b0;
      anchor_we = 1'b0;
      start     = 1'b0;
      repeat (8) tick();

      // start held high: back-to-back steps long enough to wrap frame_cnt.
      start = 1'b1;
      repeat ((STEP + 2) * (1 << FW) + 40) tick();
      start = 1'b0;
      repeat (10) tick();

      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      check("done_count", 64'(n_done), 64'(n_acc - n_abort));
      check("frame_wrap_seen", 64'(wrapped), 64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

endmodule

// File: doc/sim_step_sequencer.md
Name: sim_step_sequencer

Overview:
- Upstream controller for the cloth/rope node array; drives the phase strobes and anchor (pin) coordinates consumed by every Node instance.
- One start request runs one simulation step: a Verlet integration phase, then a fixed number of constraint-relaxation iterations, then a done pulse.
- Holds the pin target stable for the whole step and counts completed frames for the host/display side.

Parameters:
- COORD_W, 32, width of anchor coordinates.
- ANCHOR_X_INIT, 200, fix_x value after reset.
- ANCHOR_Y_INIT, 10, fix_y value after reset.
- VERLET_CYCLES, 1, cycles verlet_state is held high per step (>=1).
- CONSTRAINT_ITERS, 4, cycles fix_constraint_state is held high per step (>=1).
- FRAME_W, 16, width of frame counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; takes effect at the next rising edge of clk.
- start  in  1  request one step; sampled only in IDLE.
- anchor_we  in  1  write strobe for anchor_x/anchor_y.
- anchor_x  in  COORD_W  new pin x.
- anchor_y  in  COORD_W  new pin y.
- verlet_state  out  1  Verlet phase strobe to nodes.
- fix_constraint_state  out  1  constraint phase strobe to nodes.
- fix_x  out  COORD_W  registered pin x.
- fix_y  out  COORD_W  registered pin y.
- busy  out  1  high whenever state != IDLE.
- done  out  1  single-cycle pulse at end of step.
- frame_cnt  out  FRAME_W  completed-step count.

Behaviour:
- Reset values: state IDLE, verlet_state 0, fix_constraint_state 0, done 0, busy 0, frame_cnt 0, fix_x ANCHOR_X_INIT, fix_y ANCHOR_Y_INIT, phase counter 0.
- A reset asserted mid-step aborts the step at that edge; no done pulse; all outputs return to reset values.
- FSM states: IDLE, VERLET, CONSTRAIN, DONE. All outputs are registered and decoded from the state register.
- IDLE: start=1 -> VERLET; counter loaded to VERLET_CYCLES-1.
- VERLET: verlet_state=1; counter decrements; at 0 -> CONSTRAIN, counter loaded to CONSTRAINT_ITERS-1.
- CONSTRAIN: fix_constraint_state=1; counter decrements; at 0 -> DONE.
- DONE: done=1 for exactly one cycle; frame_cnt increments on entry to DONE; -> IDLE unconditionally.
- Latency: start sampled at edge k gives verlet_state high in cycles k+1 .. k+VERLET_CYCLES, then fix_constraint_state high for the next CONSTRAINT_ITERS cycles, then done for 1 cycle.
- verlet_state and fix_constraint_state are never high together and are never both high with done.
- start in any state other than IDLE is ignored and not queued. start held high re-triggers only from IDLE, so there is at least one IDLE cycle between steps.
- Anchor writes:
  - anchor_we is accepted only in IDLE or DONE; fix_x/fix_y update at that edge (visible the next cycle).
  - anchor_we in VERLET or CONSTRAIN is dropped.
  - anchor_we together with start in IDLE: both are accepted, and the step runs with the new anchor.
- frame_cnt wraps from 2^FRAME_W-1 to 0 with no flag.

Optional Feature:
- Macro SIM_PAUSE_EN.
- Defined: adds input port pause (1 bit).
  - While pause=1 in VERLET or CONSTRAIN, the state and counter hold, and verlet_state and fix_constraint_state read 0.
  - Releasing pause resumes with the remaining cycle count intact.
  - pause has no effect in IDLE or DONE; the done pulse is never stretched.
  - reset overrides pause.
- Undefined: no pause port; the sequence is never stalled.

Decomposition:
- Package sim_pkg holds:
  - state enum (IDLE, VERLET, CONSTRAIN, DONE);
  - COORD_W;
  - default anchor constants 200/10 shared with the node reset values.
- One natural sub-module: phase_counter, a loadable down-counter with zero flag and hold input. It is used for both the VERLET and CONSTRAIN phases.

Test Plan:
- Reset:
  - Assert reset for 2 cycles -> fix_x=200, fix_y=10, all strobes 0, busy=0, frame_cnt=0.
- Nominal step (defaults):
  - Start pulse sampled at cycle 0 -> verlet_state=1 in cycle 1.
  - fix_constraint_state=1 in cycles 2-5.
  - done=1 in cycle 6, with frame_cnt=1.
  - busy=0 in cycle 7.
- Ignored requests:
  - start re-pulsed in cycle 3 -> ignored, exactly one done.
  - anchor_we with (50,60) in cycle 3 -> fix stays (200,10).
  - The same write in IDLE -> (50,60) the next cycle.
- Reset mid-step:
  - Assert reset in cycle 4 (CONSTRAIN) -> next cycle IDLE with reset values, and no done pulse.
- Frame counter wrap:
  - Run 65536 steps -> frame_cnt wraps to 0; each step shows one done.
- Pause (SIM_PAUSE_EN):
  - pause=1 during cycles 3-5 -> fix_constraint_state low in those cycles.
  - The 4 constraint cycles complete after release; done is delayed by 3 cycles.
